// File: rtl/pcs_tx_block_sequencer.sv
// Splits 66-bit PCS blocks into 32-bit scrambler halves and inserts idle control blocks when none is offered.
// One-cycle latency: the lower half leaves on the cycle after acceptance and the upper half on the next; upstream is ready only on even, non-pause sequence values.
module pcs_tx_block_sequencer #(
  parameter int unsigned SEQ_MAX   = 32,
  parameter logic [7:0]  IDLE_TYPE = 8'h1E
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        en_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [1:0]  in_head_i,
  input  logic [63:0] in_data_i,
  output logic [31:0] data_o,
  output logic        scram_valid_o,
  output logic [1:0]  head_o,
  output logic        head_valid_o,
  output logic [5:0]  seq_o,
  output logic        idle_ins_o,
  output logic [15:0] ovf_cnt_o
);

  localparam logic [5:0] SEQ_LAST = 6'(SEQ_MAX);

  logic [5:0]  r_seq;
  logic [31:0] r_hi;
  logic [31:0] r_data;
  logic        r_scram_vld;
  logic [1:0]  r_head;
  logic        r_head_vld;
  logic [5:0]  r_seq_out;
  logic        r_idle;
  logic [15:0] r_ovf;

  logic        w_last;
  logic        w_first;

  // SEQ_MAX is even, so the pause slot never lands between the two halves of a block.
  assign w_last     = (r_seq == SEQ_LAST);
  assign w_first    = ~r_seq[0] & ~w_last;
  assign in_ready_o = en_i & w_first;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_seq       <= '0;
      r_hi        <= '0;
      r_data      <= '0;
      r_scram_vld <= 1'b0;
      r_head      <= 2'b00;
      r_head_vld  <= 1'b0;
      r_seq_out   <= '0;
      r_idle      <= 1'b0;
      r_ovf       <= '0;
    end else if (!en_i) begin
      r_seq       <= '0;
      r_scram_vld <= 1'b0;
      r_head_vld  <= 1'b0;
      r_idle      <= 1'b0;
    end else begin
      r_seq     <= w_last ? 6'd0 : r_seq + 6'd1;
      r_seq_out <= r_seq;
      if (w_last) begin
        r_scram_vld <= 1'b0;
        r_head_vld  <= 1'b0;
        r_idle      <= 1'b0;
      end else if (r_seq[0]) begin
        r_data      <= r_hi;
        r_scram_vld <= 1'b1;
        r_head_vld  <= 1'b0;
        r_idle      <= 1'b0;
      end else begin
        r_scram_vld <= 1'b1;
        r_head_vld  <= 1'b1;
        if (in_valid_i) begin
          r_data <= in_data_i[31:0];
          r_hi   <= in_data_i[63:32];
          r_head <= in_head_i;
          r_idle <= 1'b0;
        end else begin
          // The line cannot stall: fill the slot with an idle control block.
          r_data <= {24'h0, IDLE_TYPE};
          r_hi   <= '0;
          r_head <= 2'b10;
          r_idle <= 1'b1;
          if (r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
        end
      end
    end
  end

  assign data_o        = r_data;
  assign scram_valid_o = r_scram_vld;
  assign head_o        = r_head;
  assign head_valid_o  = r_head_vld;
  assign seq_o         = r_seq_out;
  assign idle_ins_o    = r_idle;
  assign ovf_cnt_o     = r_ovf;

endmodule
